// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants and control bundles for the ID/EX stage.
// Opcodes, funct codes, ALU op codes and the control-bundle layout.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_sel_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
    } ex_ctrl_t;

    typedef struct packed {
        ex_ctrl_t ex;
        imm_sel_e imm_sel;
        logic     dst_rd;
        logic     use_rs;
        logic     use_rt;
        logic     zero_rs;
    } dec_t;

endpackage

// File: rtl/id_ex_stage_control_decode.sv
// Combinational opcode/funct decoder for the ID stage.
// Unrecognised encodings fall out as an all-zero bundle (NOP).
module id_control_decode
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OP_RTYPE: begin
                dec_o.dst_rd      = 1'b1;
                dec_o.ex.regwrite = 1'b1;
                dec_o.use_rs      = 1'b1;
                dec_o.use_rt      = 1'b1;
                unique case (funct_i)
                    FN_ADD, FN_ADDU: dec_o.ex.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_o.ex.alu_op = ALU_SUB;
                    FN_AND:          dec_o.ex.alu_op = ALU_AND;
                    FN_OR:           dec_o.ex.alu_op = ALU_OR;
                    FN_XOR:          dec_o.ex.alu_op = ALU_XOR;
                    FN_NOR:          dec_o.ex.alu_op = ALU_NOR;
                    FN_SLT:          dec_o.ex.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec_o.ex.alu_op = ALU_SLL;
                        dec_o.use_rs    = 1'b0;
                    end
                    FN_SRL: begin
                        dec_o.ex.alu_op = ALU_SRL;
                        dec_o.use_rs    = 1'b0;
                    end
                    default: begin
                        dec_o.ex.regwrite = 1'b0;
                        dec_o.use_rs      = 1'b0;
                        dec_o.use_rt      = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                dec_o.ex.alu_op   = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                dec_o.ex.alusrc   = 1'b1;
                dec_o.ex.regwrite = 1'b1;
                dec_o.use_rs      = 1'b1;
            end
            OP_LW: begin
                dec_o.ex.alusrc   = 1'b1;
                dec_o.ex.regwrite = 1'b1;
                dec_o.ex.memread  = 1'b1;
                dec_o.use_rs      = 1'b1;
            end
            OP_SW: begin
                dec_o.ex.alusrc   = 1'b1;
                dec_o.ex.memwrite = 1'b1;
                dec_o.use_rs      = 1'b1;
                dec_o.use_rt      = 1'b1;
            end
            OP_BEQ: begin
                dec_o.ex.alu_op = ALU_SUB;
                dec_o.ex.branch = 1'b1;
                dec_o.use_rs    = 1'b1;
                dec_o.use_rt    = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_o.ex.alu_op   = (opcode_i == OP_ORI) ? ALU_OR : ALU_AND;
                dec_o.ex.alusrc   = 1'b1;
                dec_o.ex.regwrite = 1'b1;
                dec_o.imm_sel     = IMM_ZEXT;
                dec_o.use_rs      = 1'b1;
            end
            OP_LUI: begin
                dec_o.ex.alusrc   = 1'b1;
                dec_o.ex.regwrite = 1'b1;
                dec_o.imm_sel     = IMM_LUI;
                dec_o.zero_rs     = 1'b1;
            end
            OP_J: dec_o.ex.jump = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: operand read with WB bypass,
// load-use stall detection, branch flush and registered control for EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RA_W      = 5,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc4,
    output logic [RA_W-1:0]   ra1,
    output logic [RA_W-1:0]   ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_wa,
    output logic [4:0]        ex_shamt,
    output logic [25:0]       ex_jidx,
    output logic [31:0]       ex_pc4,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_jump
);

    dec_t              dec;
    ex_ctrl_t          ctrl, ctrl_d, ctrl_q;
    logic [RA_W-1:0]   rd_idx, wa;
    logic [DATA_W-1:0] rs_val, rt_val, imm;
    logic              hz;

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] rsv_d, rsv_q, rtv_d, rtv_q, imm_d, imm_q;
    logic [RA_W-1:0]   rs_d, rs_q, rt_d, rt_q, wa_d, wa_q;
    logic [4:0]        shamt_d, shamt_q;
    logic [25:0]       jidx_d, jidx_q;
    logic [31:0]       pc4_d, pc4_q;

    // Same-cycle WB write wins over the register file's stale read.
    function automatic logic [DATA_W-1:0] rdval(
        input logic [RA_W-1:0]   src,
        input logic [DATA_W-1:0] rf,
        input logic              we,
        input logic [RA_W-1:0]   wa_wb,
        input logic [DATA_W-1:0] wd
    );
        if (src == '0)
            return '0;
        if (WB_BYPASS && we && (wa_wb == src))
            return wd;
        return rf;
    endfunction

    id_control_decode u_dec (
        .opcode_i (id_instr[31:26]),
        .funct_i  (id_instr[5:0]),
        .dec_o    (dec)
    );

    assign ra1    = RA_W'(id_instr[25:21]);
    assign ra2    = RA_W'(id_instr[20:16]);
    assign rd_idx = RA_W'(id_instr[15:11]);

    always_comb begin
        wa     = dec.dst_rd ? rd_idx : ra2;
        rs_val = dec.zero_rs ? '0 : rdval(ra1, rd1, wb_we, wb_wa, wb_wd);
        rt_val = rdval(ra2, rd2, wb_we, wb_wa, wb_wd);
        unique case (dec.imm_sel)
            IMM_ZEXT: imm = DATA_W'({16'h0, id_instr[15:0]});
            IMM_LUI:  imm = DATA_W'({id_instr[15:0], 16'h0});
            default:  imm = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
        endcase
        ctrl          = dec.ex;
        ctrl.regwrite = dec.ex.regwrite & (wa != '0);
    end

    assign hz = id_valid & valid_q & ctrl_q.memread & (wa_q != '0)
              & ((dec.use_rs & (wa_q == ra1))
              |  (dec.use_rt & (wa_q == ra2)));

    assign id_stall = hz & ~ex_flush & ~rst;

    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        rsv_d   = '0;
        rtv_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        wa_d    = '0;
        shamt_d = '0;
        jidx_d  = '0;
        pc4_d   = '0;
        if (!(ex_flush || hz)) begin
            valid_d = id_valid;
            ctrl_d  = ctrl;
            rsv_d   = rs_val;
            rtv_d   = rt_val;
            imm_d   = imm;
            rs_d    = ra1;
            rt_d    = ra2;
            wa_d    = wa;
            shamt_d = id_instr[10:6];
            jidx_d  = id_instr[25:0];
            pc4_d   = id_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rsv_q   <= '0;
            rtv_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wa_q    <= '0;
            shamt_q <= '0;
            jidx_q  <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rsv_q   <= rsv_d;
            rtv_q   <= rtv_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wa_q    <= wa_d;
            shamt_q <= shamt_d;
            jidx_q  <= jidx_d;
            pc4_q   <= pc4_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_rs_val   = rsv_q;
    assign ex_rt_val   = rtv_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_wa       = wa_q;
    assign ex_shamt    = shamt_q;
    assign ex_jidx     = jidx_q;
    assign ex_pc4      = pc4_q;
    assign ex_alu_op   = ctrl_q.alu_op;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_branch   = ctrl_q.branch;
    assign ex_jump     = ctrl_q.jump;

endmodule
